// File: rtl/asu_ddr5_pkg.sv
// Shared types and constants for the DDR5 write strobe generator.
// Holds the FSM encoding, burst-length codes, the CRC polynomial and config decode helpers.
package asu_ddr5_pkg;

  localparam int unsigned CNT_W     = 6;
  localparam logic [7:0]  CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_BURST,
    ST_CRC,
    ST_POSTAMBLE
  } state_t;

  localparam logic [1:0] BL_16     = 2'b00;
  localparam logic [1:0] BL_8      = 2'b01;
  localparam logic [1:0] BL_32     = 2'b10;
  localparam logic [1:0] BL_16_ALT = 2'b11;

  function automatic logic [CNT_W-1:0] burst_beats(input logic [1:0] bl);
    case (bl)
      BL_8:    return CNT_W'(8);
      BL_32:   return CNT_W'(32);
      default: return CNT_W'(16);
    endcase
  endfunction

  // Preamble lengths outside 2..4 half-cycles-pairs fall back to the shortest one.
  function automatic logic [2:0] norm_pre_cycle(input logic [2:0] pc);
    return (pc >= 3'd2 && pc <= 3'd4) ? pc : 3'd2;
  endfunction

  function automatic logic [CNT_W-1:0] post_bits(input logic [1:0] pc);
    return (pc == 2'b10) ? CNT_W'(3) : CNT_W'(1);
  endfunction

endpackage

// File: rtl/asu_ddr5_crc8.sv
// Combinational CRC-8 step: folds one data byte, MSB first, into the running CRC.
module asu_ddr5_crc8
  import asu_ddr5_pkg::*;
(
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] crc_next
);

  logic [7:0] c;

  always_comb begin
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    crc_next = c;
  end

endmodule

// File: rtl/asu_ddr5_write_strobe_gen.sv
// DDR5 write path: sequences preamble, data burst, optional CRC and postamble onto DQ/DQS.
// All pin outputs are registered, so each pin value trails the state that produced it by one cycle.
module asu_ddr5_write_strobe_gen
  import asu_ddr5_pkg::*;
#(
  parameter int unsigned pDQ_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 dfi_wrdata_en_i,
  input  logic [pDQ_WIDTH-1:0] dfi_wrdata_i,
  input  logic [1:0]           burst_length_i,
  input  logic [7:0]           pre_pattern_i,
  input  logic [2:0]           pre_cycle_i,
  input  logic [1:0]           post_cycle_i,
  input  logic                 dram_crc_en_i,
  output logic                 wrdata_rdy_o,
  output logic [pDQ_WIDTH-1:0] dq_o,
  output logic                 dq_oe_o,
  output logic                 dqs_o,
  output logic                 dqs_oe_o,
  output logic                 busy_o
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       pre_pattern_q;
  logic [2:0]       pre_cycle_q;
  logic [1:0]       bl_q;
  logic [1:0]       post_q;
  logic             crc_en_q;
  logic [7:0]       crc_q;
  logic [7:0]       crc_next;

  logic [CNT_W-1:0] pre_len;
  logic [CNT_W-1:0] burst_len;
  logic [CNT_W-1:0] post_len;
  logic [2:0]       pre_idx;

  asu_ddr5_crc8 u_crc8 (
    .crc      (crc_q),
    .data     (8'(dfi_wrdata_i)),
    .crc_next (crc_next)
  );

  assign pre_len      = CNT_W'({pre_cycle_q, 1'b0});
  assign burst_len    = burst_beats(bl_q);
  assign post_len     = post_bits(post_q);
  assign pre_idx      = 3'(pre_len - CNT_W'(1) - cnt);
  assign wrdata_rdy_o = enable_i && (state == ST_BURST);
  assign busy_o       = (state != ST_IDLE);

  // FSM, bit counter, latched config, running CRC and registered pins; all frozen while disabled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      pre_pattern_q <= '0;
      pre_cycle_q   <= '0;
      bl_q          <= '0;
      post_q        <= '0;
      crc_en_q      <= 1'b0;
      crc_q         <= '0;
      dq_o          <= '0;
      dq_oe_o       <= 1'b0;
      dqs_o         <= 1'b0;
      dqs_oe_o      <= 1'b0;
    end else if (enable_i) begin
      dq_o     <= '0;
      dq_oe_o  <= 1'b0;
      dqs_o    <= 1'b0;
      dqs_oe_o <= 1'b0;
      cnt      <= cnt + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (dfi_wrdata_en_i) begin
            pre_pattern_q <= pre_pattern_i;
            pre_cycle_q   <= norm_pre_cycle(pre_cycle_i);
            bl_q          <= burst_length_i;
            post_q        <= post_cycle_i;
            crc_en_q      <= dram_crc_en_i;
            crc_q         <= '0;
            state         <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          dqs_o    <= pre_pattern_q[pre_idx];
          dqs_oe_o <= 1'b1;
          if (cnt == pre_len - CNT_W'(1)) begin
            cnt   <= '0;
            state <= ST_BURST;
          end
        end
        ST_BURST: begin
          dq_o     <= dfi_wrdata_i;
          dq_oe_o  <= 1'b1;
          dqs_o    <= ~cnt[0];
          dqs_oe_o <= 1'b1;
          crc_q    <= crc_next;
          if (cnt == burst_len - CNT_W'(1)) begin
            cnt   <= '0;
            state <= crc_en_q ? ST_CRC : ST_POSTAMBLE;
          end
        end
        ST_CRC: begin
          dq_o     <= (cnt == '0) ? pDQ_WIDTH'(crc_q) : '1;
          dq_oe_o  <= 1'b1;
          dqs_o    <= ~cnt[0];
          dqs_oe_o <= 1'b1;
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= ST_POSTAMBLE;
          end
        end
        ST_POSTAMBLE: begin
          dqs_oe_o <= 1'b1;
          if (cnt == post_len - CNT_W'(1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/asu_ddr5_write_strobe_gen.md
ASU_DDR5_WRITE_STROBE_GEN -- requirements
Module: asu_ddr5_write_strobe_gen

Interface
REQ-001 SHALL have parameter pDQ_WIDTH, default 8, DQ bits per beat (x8 device).
REQ-002 SHALL have clk_i, input, 1, bit clock; one clk_i cycle = one half-tCK unit = one DQ beat / one DQS bit.
REQ-003 SHALL have rst_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have enable_i, input, 1; when low, all state, counters and outputs hold.
REQ-005 SHALL have dfi_wrdata_en_i, input, 1, write-start request.
REQ-006 SHALL have dfi_wrdata_i, input, pDQ_WIDTH, burst data beat.
REQ-007 SHALL have burst_length_i (2), pre_pattern_i (8), pre_cycle_i (3), post_cycle_i (2), dram_crc_en_i (1), all inputs, driven by the command-address stage.
REQ-008 SHALL have wrdata_rdy_o, output, 1, high when dfi_wrdata_i is consumed this cycle.
REQ-009 SHALL have dq_o (pDQ_WIDTH), dq_oe_o (1), dqs_o (1), dqs_oe_o (1), outputs, registered DRAM-side pins.
REQ-010 SHALL have busy_o, output, 1, high in every state except IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, PREAMBLE, BURST, CRC, POSTAMBLE.
REQ-012 In IDLE with dfi_wrdata_en_i=1 SHALL latch all config inputs and enter PREAMBLE next cycle; config changes mid-write are ignored.
REQ-013 PREAMBLE SHALL last 2*pre_cycle bits; dqs_o emits pre_pattern[2*pre_cycle-1] down to [0], MSB first; pre_cycle outside 2..4 treated as 2.
REQ-014 BURST length: burst_length 00=16 beats, 01=8 beats, 10=32 beats, 11=16 beats.
REQ-015 In BURST, wrdata_rdy_o SHALL be 1 (combinational from state); dqs_o toggles starting at 1 (1,0,1,0...).
REQ-016 After the last BURST beat SHALL go to CRC if latched crc_en=1, else POSTAMBLE.
REQ-017 CRC SHALL last 2 beats: beat 0 = CRC-8 (poly 0x07, init 0x00, MSB-first, over all burst beats, bits [7:0] of each beat), beat 1 = all ones; dqs_o continues toggling.
REQ-018 POSTAMBLE SHALL last 1 bit (post_cycle 01) or 3 bits (10); 00/11 treated as 01; dqs_o=0, dq_oe_o=0, dqs_oe_o=1.
REQ-019 Outputs SHALL be registered: output values in cycle k+1 reflect the state/data of cycle k (uniform 1-cycle latency).
REQ-020 dq_oe_o SHALL be 1 only for BURST and CRC beats; dqs_oe_o SHALL be 1 for PREAMBLE, BURST, CRC, POSTAMBLE; in IDLE dq_o=0, dqs_o=0.
REQ-021 dfi_wrdata_en_i outside IDLE SHALL be ignored (no queuing); a request in the same cycle POSTAMBLE ends SHALL also be ignored.
REQ-022 Bit counter SHALL be 6 bits, reset on each state entry, no wrap-around within any state.

Reset
REQ-023 On rst_i low: state IDLE, counters 0, CRC 0x00, latched config 0, all outputs 0.
REQ-024 Reset asserted mid-write SHALL abort immediately; no postamble emitted.

Structure
REQ-025 FSM state enum, burst-length codes and CRC polynomial SHALL reside in shared package asu_ddr5_pkg.
REQ-026 CRC-8 update SHALL be sub-module asu_ddr5_crc8 (combinational next-CRC from crc and data byte).

Verification
REQ-027 Defaults (pre 00000010/2, BL16, post 01, CRC off), wrdata_en pulse -> dqs_o 0,0,1,0 then 16 toggles then one 0; dqs_oe_o high 21 cycles.
REQ-028 pre_cycle=4, pattern 00001010 -> preamble dqs_o 0,0,0,0,1,0,1,0.
REQ-029 CRC on, BL16, data 0x00 all beats -> CRC beats 0x00, 0xFF; dq_oe_o high 18 cycles.
REQ-030 burst_length=10 -> wrdata_rdy_o high exactly 32 cycles; burst_length=01 -> 8 cycles.
REQ-031 wrdata_en asserted during BURST, and rst_i pulsed mid-BURST -> request ignored; after reset all outputs 0, state IDLE.
REQ-032 enable_i low for 5 cycles mid-PREAMBLE -> dqs_o sequence resumes unchanged, total length preserved.
